// File: rtl/set_job_sched.sv
// set_job_sched: round-robin two-requester job scheduler with watchdog for the SET point-counting engine
module set_job_sched #(
  parameter int TIMEOUT = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_central,
  input  logic [11:0] req0_radius,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_central,
  input  logic [11:0] req1_radius,
  input  logic [1:0]  req1_mode,
  output logic        eng_en,
  output logic [23:0] eng_central,
  output logic [11:0] eng_radius,
  output logic [1:0]  eng_mode,
  input  logic        eng_busy,
  input  logic        eng_valid,
  input  logic [7:0]  eng_candidate,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_candidate,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  state_t state, state_nx;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  logic        cur_id, last_grant, grant, take, wd_done;
  logic [7:0]  wd;
  assign eng_central = job_central;
  assign eng_radius  = job_radius;
  assign eng_mode    = job_mode;
  assign rsp_valid   = state == RESP;
  assign rsp_id      = cur_id;
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    take       = !rst && state == IDLE && (req0_valid || req1_valid);
    req0_ready = take && !grant;
    req1_ready = take && grant;
    eng_en     = state == LAUNCH && !eng_busy;
    wd_done    = wd == WD_LAST;
    state_nx   = state == IDLE   ? (take ? LAUNCH : IDLE) :
                 state == LAUNCH ? (eng_busy ? LAUNCH : RUN) :
                 state == RUN    ? ((eng_valid || wd_done) ? RESP : RUN) :
                                   (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      job_central   <= '0;
      job_radius    <= '0;
      job_mode      <= '0;
      cur_id        <= 1'b0;
      last_grant    <= 1'b1;
      wd            <= '0;
      rsp_candidate <= '0;
      rsp_err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        job_central <= grant ? req1_central : req0_central;
        job_radius  <= grant ? req1_radius : req0_radius;
        job_mode    <= grant ? req1_mode : req0_mode;
        cur_id      <= grant;
        last_grant  <= grant;
      end
      if (eng_en) wd <= '0;
      else if (state == RUN) wd <= wd + 8'd1;
      // a result arriving on the timeout cycle takes precedence over the abort
      if (state == RUN && eng_valid) begin
        rsp_candidate <= eng_candidate;
        rsp_err       <= 1'b0;
      end else if (state == RUN && wd_done) begin
        rsp_candidate <= '0;
        rsp_err       <= 1'b1;
      end
    end
  end
endmodule

// File: doc/set_job_sched.md
# set_job_sched

Two-requester job scheduler for the shared SET point-counting engine. Accepts circle-set jobs (`central`, `radius`, `mode`) from two independent requesters and grants the engine round-robin. Holds the job operands stable on the engine for the whole run, captures `candidate` on the engine's `valid` pulse, and returns it tagged with the requester id. A watchdog bounds every run, so a hung engine cannot stall either requester.

## Interface
Parameters:
- `TIMEOUT`, default 80: maximum RUN cycles before a job is aborted with error; range 2..255.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req0_valid` in 1: requester 0 has a job.
- `req0_ready` out 1: job 0 accepted this cycle.
- `req0_central` in 24: {x1,y1,x2,y2,x3,y3}, 4 bits each.
- `req0_radius` in 12: {r1,r2,r3}.
- `req0_mode` in 2: 0 = in C1; 1 = C1∩C2; 2 = C1 xor C2; 3 = exactly two of three.
- `req1_valid`, `req1_ready`, `req1_central`, `req1_radius`, `req1_mode`: same as requester 0, for requester 1.
- `eng_en` out 1: one-cycle start pulse to engine.
- `eng_central` out 24, `eng_radius` out 12, `eng_mode` out 2: operands, stable from launch until the return to IDLE.
- `eng_busy` in 1, `eng_valid` in 1, `eng_candidate` in 8: engine status and result.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_candidate` out 8: point count; 0 when `rsp_err`=1.
- `rsp_err` out 1: job timed out.

## Operation
- States: IDLE, LAUNCH, RUN, RESP. Reset enters IDLE.
- **IDLE**
  - If exactly one `reqN_valid` is high, grant it.
  - If both are high, grant the requester not equal to `last_grant`. `last_grant` resets to 1, so req0 wins the first tie.
  - `reqN_ready` = (state==IDLE) && grant==N. It is combinational and never high for both requesters.
  - On acceptance: latch central, radius and mode into job registers, set `cur_id`=N and `last_grant`=N, then go to LAUNCH.
- **LAUNCH**
  - If `eng_busy`=0: drive `eng_en`=1 for this cycle, clear the watchdog counter, go to RUN.
  - If `eng_busy`=1: hold in LAUNCH with `eng_en`=0.
- **RUN**
  - Watchdog counter increments each cycle.
  - If `eng_valid`=1: capture `eng_candidate` into `rsp_candidate`, set `rsp_err`=0, go to RESP.
  - Else if counter reaches TIMEOUT-1: set `rsp_candidate`=0 and `rsp_err`=1, go to RESP.
  - If `eng_valid` arrives in the same cycle as the timeout, valid wins.
- **RESP**
  - `rsp_valid`=1 and `rsp_id`=`cur_id`.
  - On `rsp_ready`=1, return to IDLE. The rsp outputs hold until then.
  - No new job is accepted while in RESP.
- `eng_central`, `eng_radius` and `eng_mode` come from the job registers. They are held unchanged through LAUNCH, RUN and RESP, because the engine reads them combinationally every cycle.
- `eng_valid` outside RUN is ignored.

## Timing
- Reset values: `reqN_ready`=0 while `rst`=1; `eng_en`=0; `eng_central`/`eng_radius`/`eng_mode`=0; `rsp_valid`=0; `rsp_id`=0; `rsp_candidate`=0; `rsp_err`=0; watchdog=0.
- Launch: job accepted at edge T; `eng_en`=1 during cycle T+1 if the engine is idle.
- Result: `eng_valid` sampled high at cycle V gives `rsp_valid`=1 from cycle V+1.
- Return to IDLE: handshake at cycle H puts the block in IDLE at H+1, which can accept again in cycle H+1.
- Minimum job-to-job spacing is 3 cycles plus engine run time.
- `rst` asserted mid-job: the next edge forces IDLE and all reset values, and the in-flight job is discarded. The engine shares `rst`.
- `reqN_valid` dropping before grant is allowed; nothing is latched.

## Test plan
- **Single job, mode 0:** req0 job with central (x1,y1)=(4,4), r1=1 → `eng_en` pulse 1 cycle after accept; `rsp_valid` with `rsp_id`=0, `rsp_candidate`=5, `rsp_err`=0.
- **Edge clip:** req1 job with (x1,y1)=(1,1), r1=1, mode 0 → `rsp_id`=1, `rsp_candidate`=3.
- **Tie arbitration:** both requesters hold valid jobs back-to-back for 4 jobs → grants alternate 0,1,0,1. `eng_central` stays constant within each job; results are returned in grant order.
- **Response backpressure:** `rsp_ready`=0 for 20 cycles → `rsp_*` held stable, `req0_ready`/`req1_ready` stay 0, no `eng_en`. Release gives acceptance in the next cycle.
- **Timeout:** engine stub never raises `eng_valid`, TIMEOUT=80 → `rsp_valid` 81 cycles after `eng_en`, with `rsp_err`=1 and `rsp_candidate`=0. Also: `eng_valid` in the final RUN cycle → `rsp_err`=0.
- **Busy engine and reset:** `eng_busy`=1 at launch → FSM holds in LAUNCH until `eng_busy` drops. Asserting `rst` during RUN → all outputs at reset values next cycle. A new job then completes correctly.
